mult_div_unit: RTL and testbench
================================

# mult_div_unit

Sequential signed multiply/divide unit for the multicycle CPU. It takes the rs/rt operands from the A and B register outputs and produces the 64-bit result that loads the HI and LO datapath registers. Operations start on a one-cycle request from the control unit. The unit reports busy, done and divide-by-zero back to that control unit.

## Interface
Parameters:
- none. Data width is fixed at 32 bits, and the iteration count at 32.

Ports:
- clk  in  1  system clock; rising-edge triggered
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- mult_start  in  1  request signed multiply; sampled in IDLE only
- div_start  in  1  request signed divide; sampled in IDLE only
- a_in  in  32  operand A (rs, from A register); dividend for DIV
- b_in  in  32  operand B (rt, from B register); divisor for DIV
- hi_out  out  32  result high word; feeds HI_in
- lo_out  out  32  result low word; feeds LO_in
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when hi_out/lo_out hold a new result; drives HI_write/LO_write
- div_zero  out  1  one-cycle pulse on a divide request with b_in == 0; routed to the control unit as an exception

## Operation
States: IDLE, MULT, DIV, FIX.

IDLE:
- mult_start=1: latch a_in/b_in as magnitudes plus sign flags, clear the 64-bit accumulator and the 6-bit counter, go to MULT.
- else div_start=1 with b_in!=0: latch magnitudes and signs, clear remainder and counter, go to DIV.
- div_start=1 with b_in==0: pulse div_zero, stay in IDLE, leave hi_out/lo_out unchanged, no done.
- Both starts high: multiply wins; the divide request is dropped.
- Starts arriving outside IDLE are ignored (not queued).

MULT:
- One shift-add iteration per cycle on unsigned magnitudes.
- After 32 iterations (counter == 31 on the last one), go to FIX.

DIV:
- One restoring iteration per cycle: shift remainder:dividend left by 1, trial-subtract the divisor magnitude, set the quotient bit if the result is non-negative.
- After 32 iterations, go to FIX.

FIX (one cycle):
- Apply sign correction and register hi_out/lo_out, set done, go to IDLE.
- Multiply: product = ±(|a|·|b|); negative when sign(a) XOR sign(b). hi_out = product[63:32], lo_out = product[31:0].
- Divide (MIPS semantics): lo_out = quotient truncated toward zero, negated when sign(a) XOR sign(b). hi_out = remainder, carrying the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives lo_out = 0x80000000, hi_out = 0. This falls out of the 32-bit wrap and needs no special case.

General rules:
- Operands are used only as captured at the start edge; a_in/b_in may change afterwards.
- hi_out/lo_out hold their value between operations and change only at the FIX edge.

## Timing
All latencies below are for a start signal high in cycle N.

Multiply or valid divide:
- busy is high in cycles N+1..N+33 (32 iteration cycles, then FIX).
- done is high only in cycle N+34, with new hi_out/lo_out valid from N+34.
- busy is low in N+34; a new start in N+34 is accepted.
- Fixed latency: 34 cycles from start to done; no early termination.

Divide by zero:
- div_zero is high only in cycle N+1; busy and done stay low.

Reset:
- Values: state=IDLE, hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
- Reset mid-operation aborts without writing a result; the outputs take the reset values in the cycle after the reset edge.
- A start asserted together with reset is ignored.

## Test plan
- mult 7 × 0xFFFFFFFD (-3), start in cycle N -> done in N+34 only; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy high N+1..N+33.
- mult 0x80000000 × 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000. Follow with mult 0xFFFFFFFF × 0x00000001 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFF.
- div 0xFFFFFFF9 (-7) / 2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Follow with div 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Load the result registers with a mult, then div 5 / 0 -> div_zero high in N+1 only; done never asserted; hi_out/lo_out keep the mult result.
- mult_start and div_start together with a=6, b=4 -> multiply result hi_out=0, lo_out=24. A div_start pulse at N+5 is ignored; done occurs once, at N+34.
- Start mult 100 × 3, assert reset in cycle N+10 -> busy=0 and hi_out/lo_out=0 from N+11; no done. A new mult after reset runs to the correct result, 300.

Source files
------------

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit for the multicycle CPU.
// 32 shift-add or restoring-divide iterations, then one sign-fix cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]  state;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_q;
  logic        neg_r;
  logic        is_div;
  logic [63:0] acc;
  logic [5:0]  cnt;

  logic [32:0] add_sum;
  logic [33:0] trial;
  logic [63:0] prod_fix;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  // Magnitude of the most negative value wraps to 2^31, correct as unsigned.
  always_comb begin
    a_abs = a_in[31] ? (~a_in + 32'd1) : a_in;
    b_abs = b_in[31] ? (~b_in + 32'd1) : b_in;
  end

  // MULT: acc = {partial, multiplier}; DIV: acc = {remainder, dividend}.
  always_comb begin
    add_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    trial    = {1'b0, acc[63:31]} - {2'b00, b_mag};
    prod_fix = neg_q ? (~acc + 64'd1) : acc;
    q_fix    = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix    = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_mag    <= '0;
      b_mag    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mult_start) begin
            a_mag  <= a_abs;
            b_mag  <= b_abs;
            neg_q  <= a_in[31] ^ b_in[31];
            neg_r  <= a_in[31];
            is_div <= 1'b0;
            acc    <= {32'd0, b_abs};
            cnt    <= '0;
            state  <= MULT;
          end else if (div_start) begin
            if (b_in == 32'd0) begin
              div_zero <= 1'b1;
            end else begin
              a_mag  <= a_abs;
              b_mag  <= b_abs;
              neg_q  <= a_in[31] ^ b_in[31];
              neg_r  <= a_in[31];
              is_div <= 1'b1;
              acc    <= {32'd0, a_abs};
              cnt    <= '0;
              state  <= DIV;
            end
          end
        end
        MULT: begin
          acc <= {add_sum, acc[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        DIV: begin
          if (trial[33:32] == 2'b00)
            acc <= {trial[31:0], acc[30:0], 1'b1};
          else
            acc <= {acc[62:0], 1'b0};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi_out <= r_fix;
            lo_out <= q_fix;
          end else begin
            hi_out <= prod_fix[63:32];
            lo_out <= prod_fix[31:0];
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit.
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_unit dut (
    .clk(clk), .reset(reset),
    .mult_start(mult_start), .div_start(div_start),
    .a_in(a_in), .b_in(b_in),
    .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t tbl[14];

  int total = 0;
  int bad = 0;
  int done_cnt, done_at, dz_cnt, dz_at, busy_bad;
  logic [31:0] dhi, dlo;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called at posedge+1 of cycle N; returns at posedge+1 of cycle N+1.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    mult_start = m;
    div_start  = d;
    a_in = a;
    b_in = b;
    @(posedge clk); #1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    a_in = 32'hDEADBEEF;
    b_in = 32'h0;
  endtask

  // Observe cycles N+1..N+ncyc; busy expected high for i<=blen until reset.
  task automatic track(input int ncyc, input int blen, input int inj, input int rst);
    logic eb;
    done_cnt = 0; done_at = 0; dz_cnt = 0; dz_at = 0; busy_bad = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (i == inj) div_start = 1'b1;
      if (i == rst) reset = 1'b1;
      @(negedge clk);
      eb = (i <= blen) && (rst == 0 || i <= rst);
      if (busy !== eb) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++; done_at = i; dhi = hi_out; dlo = lo_out;
      end
      if (div_zero === 1'b1) begin
        dz_cnt++; dz_at = i;
      end
      @(posedge clk); #1;
      div_start = 1'b0;
      reset = 1'b0;
    end
  endtask

  task automatic run(input logic d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input string nm);
    start_op(!d, d, a, b);
    track(35, 33, 0, 0);
    chk({nm, " done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, " done_at"}, 64'(done_at), 64'd34);
    chk({nm, " busy"}, 64'(busy_bad), 64'd0);
    chk({nm, " dz"}, 64'(dz_cnt), 64'd0);
    chk({nm, " hi"}, {32'd0, dhi}, {32'd0, eh});
    chk({nm, " lo"}, {32'd0, dlo}, {32'd0, el});
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mul 7x-3"};
    tbl[1]  = '{1'b0, 32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, "mul min2"};
    tbl[2]  = '{1'b0, 32'hFFFFFFFF,  32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul -1x1"};
    tbl[3]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mul -1x-1"};
    tbl[4]  = '{1'b0, 32'h12345678,  32'h00000010, 32'h00000001, 32'h23456780, "mul shift"};
    tbl[5]  = '{1'b0, 32'h0000FFFF,  32'h0000FFFF, 32'h00000000, 32'hFFFE0001, "mul ffff"};
    tbl[6]  = '{1'b1, 32'hFFFFFFF9,  32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    tbl[7]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
    tbl[8]  = '{1'b1, 32'd100,       32'd7,        32'd2,        32'd14,       "div 100/7"};
    tbl[9]  = '{1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, "div -100/7"};
    tbl[10] = '{1'b1, 32'd100,       32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, "div 100/-7"};
    tbl[11] = '{1'b1, 32'd3,         32'd5,        32'd3,        32'd0,        "div 3/5"};
    tbl[12] = '{1'b1, 32'h7FFFFFFF,  32'd1,        32'd0,        32'h7FFFFFFF, "div max/1"};
    tbl[13] = '{1'b1, 32'h80000000,  32'd2,        32'd0,        32'hC0000000, "div min/2"};

    reset = 1'b1; mult_start = 1'b0; div_start = 1'b0;
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst hi", {32'd0, hi_out}, 64'd0);
    chk("rst lo", {32'd0, lo_out}, 64'd0);
    chk("rst flags", {61'd0, busy, done, div_zero}, 64'd0);
    @(posedge clk); #1;

    foreach (tbl[k]) run(tbl[k].is_div, tbl[k].a, tbl[k].b, tbl[k].hi, tbl[k].lo, tbl[k].name);

    // Divide by zero keeps the previous multiply result.
    run(1'b0, 32'd7, 32'd3, 32'd0, 32'd21, "mul 7x3");
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    track(36, 0, 0, 0);
    chk("dz cnt", 64'(dz_cnt), 64'd1);
    chk("dz at", 64'(dz_at), 64'd1);
    chk("dz done", 64'(done_cnt), 64'd0);
    chk("dz busy", 64'(busy_bad), 64'd0);
    chk("dz hold", {hi_out, lo_out}, {32'd0, 32'd21});

    // Both starts: multiply wins; a divide mid-operation is ignored.
    start_op(1'b1, 1'b1, 32'd6, 32'd4);
    track(36, 33, 5, 0);
    chk("both done_cnt", 64'(done_cnt), 64'd1);
    chk("both done_at", 64'(done_at), 64'd34);
    chk("both busy", 64'(busy_bad), 64'd0);
    chk("both res", {dhi, dlo}, {32'd0, 32'd24});

    // Reset mid-multiply aborts with no result.
    start_op(1'b1, 1'b0, 32'd100, 32'd3);
    track(36, 33, 0, 10);
    chk("abort done", 64'(done_cnt), 64'd0);
    chk("abort busy", 64'(busy_bad), 64'd0);
    chk("abort out", {hi_out, lo_out}, 64'd0);
    run(1'b0, 32'd100, 32'd3, 32'd0, 32'd300, "mul 100x3");

    // Start together with reset is ignored.
    reset = 1'b1; mult_start = 1'b1; a_in = 32'd9; b_in = 32'd9;
    @(posedge clk); #1;
    reset = 1'b0; mult_start = 1'b0;
    @(negedge clk);
    chk("rst+start busy", {63'd0, busy}, 64'd0);
    chk("rst+start out", {hi_out, lo_out}, 64'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
